// File: rtl/kaipokrandt_mem_ctrl.sv
// Wait-state memory controller between MAR/MDR and a 2**AW x 16 word array.
// Define KAIPOKRANDT_MEMCTL_WAIT_EN to take the wait-state count from wait_cfg.
module kaipokrandt_mem_ctrl #(
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [15:0] addr,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wait_cfg,
    output logic [15:0] rd_data,
    output logic        load_mem,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t         state, state_nxt;
    logic [3:0]     cnt;
    logic [3:0]     wait_load;
    logic [15:0]    addr_q;
    logic [15:0]    data_q;
    logic           op_rd_q;
    logic [15:0]    mem [2**AW];

    logic           start;
    logic           both_req;
    logic           access;
    logic           bad_addr;
    logic [AW-1:0]  idx;

`ifdef KAIPOKRANDT_MEMCTL_WAIT_EN
    assign wait_load = wait_cfg;
`else
    logic unused_wait_cfg;
    assign unused_wait_cfg = ^wait_cfg;
    assign wait_load       = '0;
`endif

    assign start    = (state == IDLE) && (rd_req ^ wr_req);
    assign both_req = (state == IDLE) && rd_req && wr_req;
    assign access   = (state == WAIT) && (cnt == '0);
    assign bad_addr = (addr_q >> AW) != 16'h0000;
    assign idx      = addr_q[AW-1:0];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)  state_nxt = WAIT;
            WAIT:    if (access) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered at the access edge so they line up with the DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            op_rd_q  <= 1'b0;
            rd_data  <= '0;
            done     <= 1'b0;
            load_mem <= 1'b0;
            err      <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_mem <= 1'b0;
            err      <= both_req;
            if (start) begin
                addr_q  <= addr;
                data_q  <= wr_data;
                op_rd_q <= rd_req;
                cnt     <= wait_load;
            end
            if (state == WAIT) begin
                if (cnt != '0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    done     <= 1'b1;
                    load_mem <= op_rd_q;
                    err      <= bad_addr;
                    if (op_rd_q) rd_data <= bad_addr ? 16'h0000 : mem[idx];
                end
            end
        end
    end

    // No reset on the array: an aborted or out-of-range write never lands.
    always_ff @(posedge clk) begin
        if (!reset && access && !op_rd_q && !bad_addr)
            mem[idx] <= data_q;
    end

endmodule
